// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the two-requester ALU arbiter.
// The arbiter connects through the slave modport; requesters and the ALU use master.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_in0;
    logic [WIDTH-1:0] req0_in1;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_in0;
    logic [WIDTH-1:0] req1_in1;
    logic [OPW-1:0]   req1_op;

    logic [WIDTH-1:0] alu_in0;
    logic [WIDTH-1:0] alu_in1;
    logic [OPW-1:0]   alu_operation;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic             rsp0_zero;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic             rsp1_zero;

    modport slave (
        input  req0_valid, req0_in0, req0_in1, req0_op,
        output req0_ready,
        input  req1_valid, req1_in0, req1_in1, req1_op,
        output req1_ready,
        output alu_in0, alu_in1, alu_operation,
        input  alu_out, alu_zero,
        output rsp0_valid, rsp0_result, rsp0_zero,
        input  rsp0_ready,
        output rsp1_valid, rsp1_result, rsp1_zero,
        input  rsp1_ready
    );

    modport master (
        output req0_valid, req0_in0, req0_in1, req0_op,
        input  req0_ready,
        output req1_valid, req1_in0, req1_in1, req1_op,
        input  req1_ready,
        input  alu_in0, alu_in1, alu_operation,
        output alu_out, alu_zero,
        input  rsp0_valid, rsp0_result, rsp0_zero,
        output rsp0_ready,
        input  rsp1_valid, rsp1_result, rsp1_zero,
        output rsp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with a
// one-entry registered response buffer per requester (1-cycle accept-to-response).
//
// state  | meaning
// PRIO_0 | requester 0 wins when both requesters are candidates
// PRIO_1 | requester 1 wins when both requesters are candidates
module alu_arbiter #(
    parameter int             WIDTH   = 32,
    parameter int             OPW     = 4,
    parameter logic [OPW-1:0] IDLE_OP = 4'b1111
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    typedef enum logic {PRIO_0 = 1'b0, PRIO_1 = 1'b1} prio_e;

    prio_e            prio_q, prio_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic             rsp0_zero_q, rsp0_zero_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic             rsp1_zero_q, rsp1_zero_d;

    logic elig0, elig1, cand0, cand1, grant0, grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q        <= PRIO_0;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            prio_q        <= prio_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

    always_comb begin
        // A full buffer being drained this cycle can take a new result.
        elig0  = !rsp0_valid_q || bus.rsp0_ready;
        elig1  = !rsp1_valid_q || bus.rsp1_ready;
        // Gating with rst_n keeps ready low while reset is held.
        cand0  = bus.req0_valid && elig0 && rst_n;
        cand1  = bus.req1_valid && elig1 && rst_n;
        grant0 = cand0 && (!cand1 || (prio_q == PRIO_0));
        grant1 = cand1 && (!cand0 || (prio_q == PRIO_1));

        prio_d = prio_q;
        if (grant0) begin
            prio_d = PRIO_1;
        end else if (grant1) begin
            prio_d = PRIO_0;
        end

        bus.alu_in0       = '0;
        bus.alu_in1       = '0;
        bus.alu_operation = IDLE_OP;
        if (grant0) begin
            bus.alu_in0       = bus.req0_in0;
            bus.alu_in1       = bus.req0_in1;
            bus.alu_operation = bus.req0_op;
        end else if (grant1) begin
            bus.alu_in0       = bus.req1_in0;
            bus.alu_in1       = bus.req1_in1;
            bus.alu_operation = bus.req1_op;
        end

        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        if (grant0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = bus.alu_out;
            rsp0_zero_d   = bus.alu_zero;
        end else if (bus.rsp0_ready) begin
            rsp0_valid_d  = 1'b0;
        end

        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        if (grant1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = bus.alu_out;
            rsp1_zero_d   = bus.alu_zero;
        end else if (bus.rsp1_ready) begin
            rsp1_valid_d  = 1'b0;
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp0_result = rsp0_result_q;
    assign bus.rsp0_zero   = rsp0_zero_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp1_result = rsp1_result_q;
    assign bus.rsp1_zero   = rsp1_zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, grant/response reference model with
// per-requester expected-result queues, and a decoupled response monitor.
`timescale 1ns/1ps
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_if #(.WIDTH(32), .OPW(4)) bus ();

    alu_arbiter #(.WIDTH(32), .OPW(4), .IDLE_OP(4'b1111)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    bit   ptr;     // 0: requester 0 preferred under contention
    bit   acc0, acc1;

    logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};

    function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_out  = alu_f(bus.alu_operation, bus.alu_in0, bus.alu_in1);
    assign bus.alu_zero = (bus.alu_out == 32'd0);

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Reference model: grant decision and expected-result push, mid-low phase.
    always @(negedge clk) begin
        bit e0, e1, c0, c1, g0, g1;
        exp_t x;
        if (!rst_n) begin
            chk("ready0_in_reset", {31'd0, bus.req0_ready}, 32'd0);
            chk("ready1_in_reset", {31'd0, bus.req1_ready}, 32'd0);
            q0.delete();
            q1.delete();
            ptr  = 1'b0;
            acc0 = 1'b0;
            acc1 = 1'b0;
        end else begin
            // Monitor has already popped a buffer drained this cycle.
            e0 = (q0.size() == 0);
            e1 = (q1.size() == 0);
            c0 = bus.req0_valid && e0;
            c1 = bus.req1_valid && e1;
            g0 = c0 && (!c1 || ptr == 1'b0);
            g1 = c1 && (!c0 || ptr == 1'b1);
            chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, g0});
            chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, g1});
            if (g0) begin
                x.res = alu_f(bus.req0_op, bus.req0_in0, bus.req0_in1);
                x.z   = (x.res == 32'd0);
                q0.push_back(x);
                ptr = 1'b1;
                chk("alu_in0_g0", bus.alu_in0, bus.req0_in0);
                chk("alu_op_g0", {28'd0, bus.alu_operation}, {28'd0, bus.req0_op});
            end else if (g1) begin
                x.res = alu_f(bus.req1_op, bus.req1_in0, bus.req1_in1);
                x.z   = (x.res == 32'd0);
                q1.push_back(x);
                ptr = 1'b0;
                chk("alu_in1_g1", bus.alu_in1, bus.req1_in1);
                chk("alu_op_g1", {28'd0, bus.alu_operation}, {28'd0, bus.req1_op});
            end else begin
                chk("idle_op", {28'd0, bus.alu_operation}, 32'hF);
                chk("idle_in0", bus.alu_in0, 32'd0);
                chk("idle_in1", bus.alu_in1, 32'd0);
            end
            acc0 = g0;
            acc1 = g1;
        end
    end

    // Response monitor: compares buffered results against the queue heads.
    always @(posedge clk) begin
        #3;
        if (!rst_n) begin
            chk("rsp0_valid_in_reset", {31'd0, bus.rsp0_valid}, 32'd0);
            chk("rsp1_valid_in_reset", {31'd0, bus.rsp1_valid}, 32'd0);
        end else begin
            chk("rsp0_valid", {31'd0, bus.rsp0_valid}, {31'd0, q0.size() > 0});
            if (bus.rsp0_valid && q0.size() > 0) begin
                chk("rsp0_result", bus.rsp0_result, q0[0].res);
                chk("rsp0_zero", {31'd0, bus.rsp0_zero}, {31'd0, q0[0].z});
                if (bus.rsp0_ready) void'(q0.pop_front());
            end
            chk("rsp1_valid", {31'd0, bus.rsp1_valid}, {31'd0, q1.size() > 0});
            if (bus.rsp1_valid && q1.size() > 0) begin
                chk("rsp1_result", bus.rsp1_result, q1[0].res);
                chk("rsp1_zero", {31'd0, bus.rsp1_zero}, {31'd0, q1[0].z});
                if (bus.rsp1_ready) void'(q1.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(bit v, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        bus.req0_valid = v; bus.req0_op = op; bus.req0_in0 = a; bus.req0_in1 = b;
    endtask

    task automatic set1(bit v, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        bus.req1_valid = v; bus.req1_op = op; bus.req1_in0 = a; bus.req1_in1 = b;
    endtask

    task automatic idle(int n);
        set0(1'b0, 4'd0, 32'd0, 32'd0);
        set1(1'b0, 4'd0, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (n) tick();
    endtask

    function automatic logic [31:0] rnd_opnd(logic [31:0] other);
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 7);
            1:       return $urandom;
            2:       return 32'h8000_0000 | $urandom_range(0, 3);
            default: return other;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        rst_n = 1'b0;
        set0(1'b1, 4'd2, 32'd1, 32'd1);
        set1(1'b1, 4'd2, 32'd2, 32'd2);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #2;
        chk("reset_rsp0_result", bus.rsp0_result, 32'd0);
        chk("reset_rsp0_zero", {31'd0, bus.rsp0_zero}, 32'd0);
        chk("reset_rsp1_result", bus.rsp1_result, 32'd0);
        chk("reset_rsp1_zero", {31'd0, bus.rsp1_zero}, 32'd0);
        chk("reset_ready0", {31'd0, bus.req0_ready}, 32'd0);
        repeat (2) tick();
        idle(0);
        rst_n = 1'b1;
        tick();

        // Single ADD 5+7.
        set0(1'b1, 4'd2, 32'd5, 32'd7);
        tick();
        idle(2);

        // Contention: SUB 9-9 versus OR F0|0F.
        set0(1'b1, 4'd6, 32'd9, 32'd9);
        set1(1'b1, 4'd1, 32'hF0, 32'h0F);
        repeat (4) tick();
        idle(2);

        // Backpressure on requester 0 while requester 1 streams.
        set0(1'b1, 4'd7, 32'd3, 32'd4);
        set1(1'b1, 4'd2, 32'd1, 32'd2);
        bus.rsp0_ready = 1'b0;
        repeat (5) tick();
        bus.rsp0_ready = 1'b1;
        repeat (2) tick();
        idle(2);

        // Idle drive and unsupported op on requester 1.
        #1;
        chk("idle_direct_op", {28'd0, bus.alu_operation}, 32'hF);
        chk("idle_direct_in0", bus.alu_in0, 32'd0);
        set1(1'b1, 4'd3, 32'd10, 32'd20);
        tick();
        idle(2);

        // AND / NOR sweep.
        set0(1'b1, 4'd0, 32'hFFFF_0000, 32'h00FF_00FF);
        set1(1'b1, 4'd12, 32'hFFFF_0000, 32'h00FF_00FF);
        repeat (2) tick();
        idle(2);

        // Randomised traffic with operand hold while not accepted.
        for (int i = 0; i < 3000; i++) begin
            if (!(bus.req0_valid && !acc0)) begin
                a = rnd_opnd(32'd0);
                set0($urandom_range(0, 3) != 0, ops[$urandom_range(0, 7)], a, rnd_opnd(a));
            end
            if (!(bus.req1_valid && !acc1)) begin
                a = rnd_opnd(32'd1);
                set1($urandom_range(0, 3) != 0, ops[$urandom_range(0, 7)], a, rnd_opnd(a));
            end
            bus.rsp0_ready = $urandom_range(0, 9) < 7;
            bus.rsp1_ready = $urandom_range(0, 9) < 7;
            tick();
        end
        idle(3);

        // Async reset with rsp1 full and a grant to requester 0 in flight.
        set1(1'b1, 4'd2, 32'd3, 32'd3);
        bus.rsp1_ready = 1'b0;
        tick();
        set1(1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        set0(1'b1, 4'd2, 32'd8, 32'd8);
        #1;
        chk("pre_reset_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
        rst_n = 1'b0;
        #0.5;
        chk("async_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("async_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        tick();
        tick();
        set0(1'b1, 4'd1, 32'h1, 32'h2);
        set1(1'b1, 4'd1, 32'h4, 32'h8);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_grant0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        tick();
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
